// File: rtl/flit_arbiter.sv
// Round-robin flit arbiter with packet locking: selects one of NUM_PORTS flit
// sources, holds the grant until the packet tail, and forwards through one output register.
package types;
    typedef struct packed {
        logic [7:0]  src_id;
        logic [7:0]  dst_id;
        logic [15:0] payload;
    } flit_t;
endpackage

module flit_arbiter #(
    parameter int NUM_PORTS = 4,
    parameter int PORT_W    = $clog2(NUM_PORTS)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  types::flit_t [NUM_PORTS-1:0] in_flit,
    input  logic [NUM_PORTS-1:0]         in_flit_valid,
    input  logic [NUM_PORTS-1:0]         in_flit_last,
    output logic [NUM_PORTS-1:0]         in_flit_ready,
    output types::flit_t                 out_flit,
    output logic                         out_flit_valid,
    input  logic                         out_flit_ready,
    output logic [PORT_W-1:0]            out_port,
    output logic                         out_flit_last,
    output logic                         busy
);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t            state_r;
    state_t            state_s;
    logic [PORT_W-1:0] rr_ptr_r;
    logic [PORT_W-1:0] rr_ptr_s;
    logic [PORT_W-1:0] lock_port_r;
    logic [PORT_W-1:0] lock_port_s;

    logic              sel_found_s;
    logic [PORT_W-1:0] sel_port_s;
    logic [PORT_W-1:0] grant_port_s;
    logic              grant_en_s;
    logic              can_load_s;
    logic              xfer_s;
    logic              xfer_last_s;

    function automatic logic [PORT_W-1:0] port_inc(input logic [PORT_W-1:0] p);
        logic [PORT_W-1:0] r;
        if (p == PORT_W'(NUM_PORTS - 1)) begin
            r = {PORT_W{1'b0}};
        end else begin
            r = p + PORT_W'(1);
        end
        return r;
    endfunction

    // Round-robin search for the first valid port starting at rr_ptr.
    always_comb begin
        int  idx;
        logic hit;
        idx         = 0;
        hit         = 1'b0;
        sel_found_s = 1'b0;
        sel_port_s  = {PORT_W{1'b0}};
        for (int k = 0; k < NUM_PORTS; k++) begin
            idx         = (int'(rr_ptr_r) + k) % NUM_PORTS;
            hit         = !sel_found_s && in_flit_valid[idx];
            sel_port_s  = hit ? PORT_W'(idx) : sel_port_s;
            sel_found_s = sel_found_s || hit;
        end
    end

    // Grant generation; a locked port is offered ready even while its valid is low.
    always_comb begin
        can_load_s    = !out_flit_valid || out_flit_ready;
        grant_en_s    = (state_r == ST_LOCKED) || sel_found_s;
        grant_port_s  = (state_r == ST_LOCKED) ? lock_port_r : sel_port_s;
        in_flit_ready = {NUM_PORTS{1'b0}};
        in_flit_ready[grant_port_s] = rst_n && can_load_s && grant_en_s;
        xfer_s        = grant_en_s && can_load_s && in_flit_valid[grant_port_s];
        xfer_last_s   = in_flit_last[grant_port_s];
    end

    // Next-state: lock on a non-tail transfer, release and advance rr_ptr on a tail.
    always_comb begin
        state_s     = state_r;
        rr_ptr_s    = rr_ptr_r;
        lock_port_s = lock_port_r;
        if (xfer_s) begin
            case (state_r)
                ST_IDLE: begin
                    if (xfer_last_s) begin
                        rr_ptr_s = port_inc(grant_port_s);
                    end else begin
                        state_s     = ST_LOCKED;
                        lock_port_s = grant_port_s;
                    end
                end
                ST_LOCKED: begin
                    if (xfer_last_s) begin
                        state_s  = ST_IDLE;
                        rr_ptr_s = port_inc(lock_port_r);
                    end else begin
                        state_s = ST_LOCKED;
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                end
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // Arbitration state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            rr_ptr_r    <= {PORT_W{1'b0}};
            lock_port_r <= {PORT_W{1'b0}};
        end else begin
            state_r     <= state_s;
            rr_ptr_r    <= rr_ptr_s;
            lock_port_r <= lock_port_s;
        end
    end

    // Output register: reload on input transfer (no bubble), clear valid on drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_flit       <= '{src_id: 8'h00, dst_id: 8'h00, payload: 16'h0000};
            out_flit_valid <= 1'b0;
            out_port       <= {PORT_W{1'b0}};
            out_flit_last  <= 1'b0;
        end else if (xfer_s) begin
            out_flit       <= in_flit[grant_port_s];
            out_flit_valid <= 1'b1;
            out_port       <= grant_port_s;
            out_flit_last  <= xfer_last_s;
        end else if (out_flit_ready) begin
            out_flit_valid <= 1'b0;
        end else begin
            out_flit_valid <= out_flit_valid;
        end
    end

    assign busy = (state_r == ST_LOCKED);

endmodule
